// File: rtl/hier_deser_pkg.sv
// Shared types and defaults for the hier_deser serial-to-parallel receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Optional feature macro used by this block: DESER_PARITY_EN.
package hier_deser_pkg;

  // PARITY is only entered when DESER_PARITY_EN is defined.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } deser_state_t;

  localparam int DESER_WIDTH_DEF   = 8;
  localparam int DESER_TIMEOUT_DEF = 16;

endpackage

// File: rtl/hier_deser_if.sv
// Serial link in / parallel word out bundle for hier_deser.
// Latency: n/a (wiring only).
// Backpressure: none; the serial side is strobe-driven and the parallel side is a valid pulse.
// Ports: ser_in/ser_valid/start (serial side), dout/dout_valid/busy/frame_err/parity_err (parallel side).
// Modports: slave = the receiver, master = whoever drives the link and consumes the word.
interface hier_deser_if
  import hier_deser_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH_DEF
) ();

  logic             ser_in;
  logic             ser_valid;
  logic             start;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             busy;
  logic             frame_err;
  logic             parity_err;

  modport slave (
    input  ser_in, ser_valid, start,
    output dout, dout_valid, busy, frame_err, parity_err
  );

  modport master (
    output ser_in, ser_valid, start,
    input  dout, dout_valid, busy, frame_err, parity_err
  );

endinterface

// File: rtl/hier_deser_bitcnt.sv
// Bit position counter and inter-strobe timeout counter for hier_deser.
// Latency: counters update on the edge after their controls; last_bit/timed_out are combinational.
// Backpressure: none.
// Ports: clk, rst_n; first (bit 0 captured), step (later bit captured), clr (frame done),
//        tick (active frame, no strobe); cnt, last_bit (cnt is final data position), timed_out.
module hier_deser_bitcnt
  import hier_deser_pkg::*;
#(
  parameter int WIDTH   = DESER_WIDTH_DEF,
  parameter int TIMEOUT = DESER_TIMEOUT_DEF,
  localparam int CW     = $clog2(WIDTH + 1),
  localparam int TW     = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          first,
  input  logic          step,
  input  logic          clr,
  input  logic          tick,
  output logic [CW-1:0] cnt,
  output logic          last_bit,
  output logic          timed_out
);

  logic [TW-1:0] tmo;

  assign last_bit = (cnt == CW'(WIDTH - 1));
  // Fires on the idle cycle that brings tmo up to TIMEOUT.
  assign timed_out = tick && (tmo == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      tmo <= '0;
    end else if (first) begin
      // A start bit always counts as bit 0, even when it aborts a frame.
      cnt <= CW'(1);
      tmo <= '0;
    end else if (clr || timed_out) begin
      cnt <= '0;
      tmo <= '0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      tmo <= '0;
    end else if (tick) begin
      tmo <= tmo + 1'b1;
    end
  end

endmodule

// File: rtl/hier_deser.sv
// Serial-to-parallel receiver: collects WIDTH strobed bits into a word, pulses dout_valid per frame.
// Latency: dout/dout_valid one cycle after the final strobe (the parity strobe when DESER_PARITY_EN).
// Backpressure: none; link is strobe-driven, aborted frames pulse frame_err, bad parity pulses parity_err.
// Ports: clk, rst_n (async active-low), link (hier_deser_if.slave).
// Optional feature macro: DESER_PARITY_EN adds one even-parity bit after the data bits.
module hier_deser
  import hier_deser_pkg::*;
#(
  parameter int WIDTH     = DESER_WIDTH_DEF,
  parameter int LSB_FIRST = 1,
  parameter int TIMEOUT   = DESER_TIMEOUT_DEF
) (
  input logic          clk,
  input logic          rst_n,
  hier_deser_if.slave  link
);

  localparam int CW = $clog2(WIDTH + 1);

  deser_state_t     state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] cap_word;
  logic [WIDTH-1:0] dout_q;
  logic             dout_valid_q;
  logic             frame_err_q;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    idx;
  logic             last_bit;
  logic             timed_out;
  logic             active;
  logic             begin_frame;
  logic             shift_bit;
  logic             wait_tick;
  logic             clr;

  assign active      = (state != IDLE);
  // A start strobe opens a frame from any state; outside IDLE it is also an abort.
  assign begin_frame = link.ser_valid & link.start;
  assign shift_bit   = link.ser_valid & ~link.start & (state == SHIFT);
  assign wait_tick   = ~link.ser_valid & active;

`ifdef DESER_PARITY_EN
  logic par_bit;
  logic parity_err_q;
  assign par_bit = link.ser_valid & ~link.start & (state == PARITY);
  assign clr     = (shift_bit & last_bit) | par_bit;
`else
  assign clr     = shift_bit & last_bit;
`endif

  hier_deser_bitcnt #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) u_bitcnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .first     (begin_frame),
    .step      (shift_bit),
    .clr       (clr),
    .tick      (wait_tick),
    .cnt       (cnt),
    .last_bit  (last_bit),
    .timed_out (timed_out)
  );

  // Word as it looks with the current strobe merged in; a start bit begins from a clean word
  // so nothing from an aborted frame can leak into the new one.
  always_comb begin
    idx = begin_frame ? '0 : cnt;
    if (LSB_FIRST == 0) idx = CW'(WIDTH - 1) - idx;
    cap_word = begin_frame ? '0 : shreg;
    for (int i = 0; i < WIDTH; i++) begin
      if (idx == CW'(i)) cap_word[i] = link.ser_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shreg        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef DESER_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef DESER_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      // Restart outranks completion and timeout, which cannot coincide with a strobe anyway.
      if (begin_frame) begin
        frame_err_q <= active;
        shreg       <= cap_word;
        state       <= SHIFT;
      end else if (shift_bit) begin
        shreg <= cap_word;
        if (last_bit) begin
`ifdef DESER_PARITY_EN
          state <= PARITY;
`else
          dout_q       <= cap_word;
          dout_valid_q <= 1'b1;
          state        <= IDLE;
`endif
        end
      end
`ifdef DESER_PARITY_EN
      else if (par_bit) begin
        state <= IDLE;
        // Even parity: data ones plus the parity bit must total an even count.
        if (link.ser_in == ^shreg) begin
          dout_q       <= shreg;
          dout_valid_q <= 1'b1;
        end else begin
          parity_err_q <= 1'b1;
        end
      end
`endif
      else if (timed_out) begin
        frame_err_q <= 1'b1;
        shreg       <= '0;
        state       <= IDLE;
      end
    end
  end

  assign link.dout       = dout_q;
  assign link.dout_valid = dout_valid_q;
  assign link.busy       = active;
  assign link.frame_err  = frame_err_q;
`ifdef DESER_PARITY_EN
  assign link.parity_err = parity_err_q;
`else
  assign link.parity_err = 1'b0;
`endif

endmodule
